// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Bus bundle between a byte-stream source, the image loader and
//               the memory write port.
//                 in_data / in_valid / in_ready : byte stream, valid/ready
//                 mem_write_en                  : one-cycle word write strobe
//                 mem_write_addr                : byte address (multiple of 4)
//                 mem_write_data                : assembled big-endian word
//               master : host side (drives the stream, observes the writes)
//               slave  : loader side (consumes the stream, issues writes)
// Revision    : 1.0  initial release
// ============================================================================
interface imem_loader_if #(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_write_en;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [WORD_SIZE-1:0]  mem_write_data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_write_en,
        input  mem_write_addr,
        input  mem_write_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_write_en,
        output mem_write_addr,
        output mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time program loader. Consumes a byte stream
//               (count N, 4*N big-endian data bytes, XOR checksum), writes
//               each assembled word to memory with a one-cycle strobe, and
//               releases the processor only after the checksum matches.
// Ports       : clk_i         - clock, rising edge
//               rst_ni        - asynchronous active-low reset
//               start_i       - single-cycle load request
//               bus (slave)   - byte stream in, memory write port out
//               cpu_hold_o    - 1 holds the processor in reset
//               load_done_o   - image loaded and checksum matched
//               load_error_o  - bad word count or checksum mismatch
// Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int WORD_SIZE  = 32,  // memory word width, must be 32
    parameter int ADDR_WIDTH = 8    // byte-address width of memory
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    imem_loader_if.slave bus,
    output logic         cpu_hold_o,
    output logic         load_done_o,
    output logic         load_error_o
);

    localparam int MAX_WORDS = 2 ** (ADDR_WIDTH - 2);
    // Word index must be able to hold MAX_WORDS itself (the terminal count).
    localparam int IDX_W     = ADDR_WIDTH - 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_e;

    state_e                state_q;
    state_e                state_d;

    logic [7:0]            count_q;
    logic [7:0]            xor_q;
    logic [IDX_W-1:0]      word_idx_q;
    logic [1:0]            byte_idx_q;
    // Only the first three bytes of a word need storage; the fourth byte is
    // taken straight from the stream when the word is committed.
    logic [WORD_SIZE-9:0]  word_q;

    logic                  in_ready_q;
    logic                  mem_write_en_q;
    logic [ADDR_WIDTH-1:0] mem_write_addr_q;
    logic [WORD_SIZE-1:0]  mem_write_data_q;
    logic                  cpu_hold_q;
    logic                  load_done_q;
    logic                  load_error_q;

    logic                  w_xfer;
    logic                  w_count_bad;
    logic                  w_last_word;
    logic [IDX_W-1:0]      w_idx_inc;

    // in_ready_q is a pure function of the current state, so the handshake
    // never depends combinationally on in_valid.
    assign w_xfer      = bus.in_valid & in_ready_q;
    assign w_count_bad = (bus.in_data == 8'd0) ||
                         ({24'd0, bus.in_data} > 32'(MAX_WORDS));
    assign w_idx_inc   = word_idx_q + 1'b1;
    assign w_last_word = (32'(w_idx_inc) == {24'd0, count_q});

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_HEADER;
            end
            S_HEADER: begin
                if (w_xfer) state_d = w_count_bad ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                if (w_xfer && (byte_idx_q == 2'd3)) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = w_last_word ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (w_xfer) state_d = (bus.in_data == xor_q) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (start_i) state_d = S_HEADER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, datapath and registered outputs. Outputs are registered from
    // state_d so that they line up with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= S_IDLE;
            count_q          <= '0;
            xor_q            <= '0;
            word_idx_q       <= '0;
            byte_idx_q       <= '0;
            word_q           <= '0;
            in_ready_q       <= 1'b0;
            mem_write_en_q   <= 1'b0;
            mem_write_addr_q <= '0;
            mem_write_data_q <= '0;
            cpu_hold_q       <= 1'b1;
            load_done_q      <= 1'b0;
            load_error_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= (state_d == S_HEADER) || (state_d == S_DATA) ||
                              (state_d == S_CHECK);
            mem_write_en_q <= (state_d == S_WRITE);
            cpu_hold_q     <= (state_d != S_DONE);
            load_done_q    <= (state_d == S_DONE);
            load_error_q   <= (state_d == S_ERROR);

            case (state_q)
                S_HEADER: begin
                    if (w_xfer) begin
                        count_q    <= bus.in_data;
                        xor_q      <= bus.in_data;
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        word_q     <= {word_q[WORD_SIZE-17:0], bus.in_data};
                        xor_q      <= xor_q ^ bus.in_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        // Fourth byte: commit address and word for the
                        // write strobe in the following cycle.
                        if (byte_idx_q == 2'd3) begin
                            mem_write_addr_q <= {word_idx_q[ADDR_WIDTH-3:0], 2'b00};
                            mem_write_data_q <= {word_q, bus.in_data};
                        end
                    end
                end
                S_WRITE: begin
                    word_idx_q <= w_idx_inc;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.mem_write_en   = mem_write_en_q;
    assign bus.mem_write_addr = mem_write_addr_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign cpu_hold_o         = cpu_hold_q;
    assign load_done_o        = load_done_q;
    assign load_error_o       = load_error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader. Each scenario
//               task drives a byte stream and compares the observed writes,
//               handshake and status flags with hand-computed values.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold;
    logic load_done;
    logic load_error;

    imem_loader_if #(.WORD_SIZE(32), .ADDR_WIDTH(8)) bus_if ();

    imem_loader #(.WORD_SIZE(32), .ADDR_WIDTH(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .bus          (bus_if.slave),
        .cpu_hold_o   (cpu_hold),
        .load_done_o  (load_done),
        .load_error_o (load_error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_xfer   = 0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  stream[$];

    // Expected writes of the nominal two-word image.
    logic [7:0]  nom_addr[2] = '{8'h00, 8'h04};
    logic [31:0] nom_data[2] = '{32'h20080005, 32'h01095020};

    always @(posedge clk) cyc <= cyc + 1;

    // Observers sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus_if.mem_write_en) begin
            wr_addr.push_back(bus_if.mem_write_addr);
            wr_data.push_back(bus_if.mem_write_data);
        end
        if (bus_if.in_valid && bus_if.in_ready) n_xfer <= n_xfer + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    // Present one byte and return 1 ns after the edge that consumed it.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bus_if.in_data  = b;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus_if.in_ready) begin
                ok = 1'b1;
                step();
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_byte_timeout byte=%h in_ready=%b required 1", b, bus_if.in_ready);
        end
    endtask

    task automatic send_stream();
        foreach (stream[i]) send_byte(stream[i]);
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 20 && !(load_done || load_error); i++) step();
    endtask

    task automatic load_nominal(input logic [7:0] chk);
        stream = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, chk};
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL reset_cpu_hold got=%b exp=1", cpu_hold); end
        checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL reset_load_done got=%b exp=0", load_done); end
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL reset_load_error got=%b exp=0", load_error); end
        checks++; if (bus_if.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus_if.in_ready); end
        checks++; if (bus_if.mem_write_en !== 1'b0) begin failures++; $display("FAIL reset_write_en got=%b exp=0", bus_if.mem_write_en); end
        checks++; if (bus_if.mem_write_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", bus_if.mem_write_addr); end
        checks++; if (bus_if.mem_write_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus_if.mem_write_data); end
        rst_n = 1'b1;
        // A byte offered in IDLE must not be consumed.
        bus_if.in_data  = 8'hAA;
        bus_if.in_valid = 1'b1;
        repeat (3) step();
        checks++; if (bus_if.in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready got=%b exp=0", bus_if.in_ready); end
        checks++; if (n_xfer !== 0) begin failures++; $display("FAIL idle_no_xfer got=%0d exp=0", n_xfer); end
        bus_if.in_valid = 1'b0;
    endtask

    task automatic test_nominal();
        int c0;
        clear_writes();
        pulse_start();
        c0 = cyc;
        checks++; if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL header_in_ready got=%b exp=1", bus_if.in_ready); end
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL header_cpu_hold got=%b exp=1", cpu_hold); end
        load_nominal(8'h57);
        for (int i = 0; i < 9; i++) send_byte(stream[i]);
        checks++; if ({cpu_hold, load_done} !== 2'b10) begin failures++; $display("FAIL check_state_flags got=%b exp=10", {cpu_hold, load_done}); end
        send_byte(stream[9]);
        bus_if.in_valid = 1'b0;
        wait_end();
        checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL nom_load_done got=%b exp=1", load_done); end
        checks++; if (cyc - c0 !== 12) begin failures++; $display("FAIL nom_latency got=%0d exp=12", cyc - c0); end
        checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL nom_cpu_hold got=%b exp=0", cpu_hold); end
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL nom_load_error got=%b exp=0", load_error); end
        checks++; if (wr_addr.size() !== 2) begin failures++; $display("FAIL nom_write_count got=%0d exp=2", wr_addr.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (wr_addr[i] !== nom_addr[i] || wr_data[i] !== nom_data[i]) begin
                failures++;
                $display("FAIL nom_write%0d got=%h:%h exp=%h:%h", i, wr_addr[i], wr_data[i], nom_addr[i], nom_data[i]);
            end
        end
    endtask

    task automatic test_bad_checksum();
        clear_writes();
        pulse_start();
        checks++; if ({cpu_hold, load_done} !== 2'b10) begin failures++; $display("FAIL reload_flags got=%b exp=10", {cpu_hold, load_done}); end
        load_nominal(8'h56);
        send_stream();
        wait_end();
        checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL badsum_error got=%b exp=1", load_error); end
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL badsum_cpu_hold got=%b exp=1", cpu_hold); end
        checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL badsum_done got=%b exp=0", load_done); end
        checks++; if (wr_addr.size() !== 2) begin failures++; $display("FAIL badsum_write_count got=%0d exp=2", wr_addr.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (wr_addr[i] !== nom_addr[i] || wr_data[i] !== nom_data[i]) begin
                failures++;
                $display("FAIL badsum_write%0d got=%h:%h exp=%h:%h", i, wr_addr[i], wr_data[i], nom_addr[i], nom_data[i]);
            end
        end
    endtask

    task automatic test_bad_count();
        logic [7:0] bad[2] = '{8'h00, 8'h41};
        for (int k = 0; k < 2; k++) begin
            clear_writes();
            pulse_start();
            checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL badcnt%0d_error_cleared got=%b exp=0", k, load_error); end
            send_byte(bad[k]);
            bus_if.in_valid = 1'b0;
            checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL badcnt%0d_error got=%b exp=1", k, load_error); end
            checks++; if (bus_if.in_ready !== 1'b0) begin failures++; $display("FAIL badcnt%0d_in_ready got=%b exp=0", k, bus_if.in_ready); end
            repeat (3) step();
            checks++; if (wr_addr.size() !== 0) begin failures++; $display("FAIL badcnt%0d_writes got=%0d exp=0", k, wr_addr.size()); end
        end
    endtask

    task automatic test_backpressure();
        int x0;
        clear_writes();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'h08);
        bus_if.in_valid = 1'b0;
        x0 = n_xfer;
        repeat (3) step();
        checks++; if (n_xfer !== x0) begin failures++; $display("FAIL stall_xfer got=%0d exp=%0d", n_xfer, x0); end
        checks++; if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL stall_in_ready got=%b exp=1", bus_if.in_ready); end
        send_byte(8'h00);
        send_byte(8'h05);
        // Now in the WRITE cycle: offer the next byte; it must wait.
        checks++; if (bus_if.mem_write_en !== 1'b1) begin failures++; $display("FAIL bp_write_en got=%b exp=1", bus_if.mem_write_en); end
        checks++; if (bus_if.in_ready !== 1'b0) begin failures++; $display("FAIL bp_write_in_ready got=%b exp=0", bus_if.in_ready); end
        bus_if.in_data = 8'h01;
        x0 = n_xfer;
        step();
        checks++; if (n_xfer !== x0) begin failures++; $display("FAIL bp_write_consumed got=%0d exp=%0d", n_xfer, x0); end
        stream = '{8'h01, 8'h09, 8'h50, 8'h20, 8'h57};
        send_stream();
        wait_end();
        checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", load_done); end
        checks++; if (wr_addr.size() !== 2) begin failures++; $display("FAIL bp_write_count got=%0d exp=2", wr_addr.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (wr_addr[i] !== nom_addr[i] || wr_data[i] !== nom_data[i]) begin
                failures++;
                $display("FAIL bp_write%0d got=%h:%h exp=%h:%h", i, wr_addr[i], wr_data[i], nom_addr[i], nom_data[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        stream = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
        send_stream();
        // In the WRITE cycle of word 0: assert reset between clock edges.
        checks++; if (bus_if.mem_write_data !== 32'h20080005) begin failures++; $display("FAIL mid_pre_data got=%h exp=20080005", bus_if.mem_write_data); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL mid_cpu_hold got=%b exp=1", cpu_hold); end
        checks++; if (bus_if.mem_write_en !== 1'b0) begin failures++; $display("FAIL mid_write_en got=%b exp=0", bus_if.mem_write_en); end
        checks++; if (bus_if.mem_write_data !== 32'h0) begin failures++; $display("FAIL mid_data got=%h exp=0", bus_if.mem_write_data); end
        checks++; if (bus_if.mem_write_addr !== 8'h00) begin failures++; $display("FAIL mid_addr got=%h exp=00", bus_if.mem_write_addr); end
        checks++; if ({bus_if.in_ready, load_done, load_error} !== 3'b000) begin failures++; $display("FAIL mid_flags got=%b exp=000", {bus_if.in_ready, load_done, load_error}); end
        rst_n = 1'b1;
        step();
        clear_writes();
        pulse_start();
        load_nominal(8'h57);
        send_stream();
        wait_end();
        checks++; if ({load_done, cpu_hold} !== 2'b10) begin failures++; $display("FAIL mid_reload_done got=%b exp=10", {load_done, cpu_hold}); end
        checks++; if (wr_data.size() !== 2 || wr_data[1] !== 32'h01095020) begin failures++; $display("FAIL mid_reload_writes got=%0d last=%h exp=2 01095020", wr_data.size(), wr_data[1]); end
    endtask

    task automatic test_reload_max();
        logic [7:0]  x;
        logic [31:0] w;
        logic [7:0]  b[4];
        clear_writes();
        pulse_start();
        checks++; if ({cpu_hold, load_done} !== 2'b10) begin failures++; $display("FAIL max_reload_flags got=%b exp=10", {cpu_hold, load_done}); end
        stream.delete();
        stream.push_back(8'h40);
        x = 8'h40;
        for (int i = 0; i < 64; i++) begin
            b[0] = 8'(i);
            b[1] = 8'(i) ^ 8'hA5;
            b[2] = 8'h3C;
            b[3] = ~8'(i);
            for (int j = 0; j < 4; j++) begin
                stream.push_back(b[j]);
                x = x ^ b[j];
            end
        end
        stream.push_back(x);
        send_stream();
        wait_end();
        checks++; if ({load_done, cpu_hold, load_error} !== 3'b100) begin failures++; $display("FAIL max_done got=%b exp=100", {load_done, cpu_hold, load_error}); end
        checks++; if (wr_addr.size() !== 64) begin failures++; $display("FAIL max_write_count got=%0d exp=64", wr_addr.size()); end
        checks++; if (wr_addr[63] !== 8'hFC || wr_data[63] !== 32'h3F9A3CC0) begin failures++; $display("FAIL max_last_write got=%h:%h exp=fc:3f9a3cc0", wr_addr[63], wr_data[63]); end
        for (int i = 0; i < 64; i++) begin
            w = {8'(i), 8'(i) ^ 8'hA5, 8'h3C, ~8'(i)};
            checks++;
            if (wr_addr[i] !== 8'(i * 4) || wr_data[i] !== w) begin
                failures++;
                $display("FAIL max_write%0d got=%h:%h exp=%h:%h", i, wr_addr[i], wr_data[i], 8'(i * 4), w);
            end
        end
    endtask

    initial begin
        bus_if.in_data  = 8'h00;
        bus_if.in_valid = 1'b0;
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_bad_count();
        test_backpressure();
        test_reset_mid();
        test_reload_max();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
